// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default baud divisor.
// Used by the load path (uart_datamemload) and the transmit-side dump block.
package uart_pkg;

  // 50 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_datamemload_if.sv
// Datamem write port: byte enables, word address, write data.
// master drives the bus (loader), slave receives it (datamem).
interface uart_datamemload_if;
  logic [3:0]  con_write;
  logic [9:0]  con_addr;
  logic [31:0] con_in;

  modport master (
    output con_write,
    output con_addr,
    output con_in
  );

  modport slave (
    input con_write,
    input con_addr,
    input con_in
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop RX synchronizer.
// Ports: CLK, rst, RX in; data, byte_valid, frame_err pulse, busy out.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  // bad stop bit seen; stay in STOP until the line idles high
  logic          hold;

  always_ff @(posedge CLK) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx         <= 1'b1;
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      hold       <= 1'b0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta    <= RX;
      rx         <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            if (rx) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            shreg   <= {rx, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (hold) begin
            if (rx) begin
              hold  <= 1'b0;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            if (rx) begin
              data       <= shreg;
              byte_valid <= 1'b1;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              hold      <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_datamemload.sv
// Loads datamem over UART: 4 bytes little-endian per word, sequential addr.
// Ports: CLK, rst, RX in; mem (write bus), busy, done, frame_err out.
module uart_datamemload
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int NUM_WORDS    = 1024
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  RX,
  uart_datamemload_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err
);

  localparam logic [9:0] LAST = 10'(NUM_WORDS - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic [1:0] byte_idx;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK       (CLK),
    .rst       (rst),
    .RX        (RX),
    .data      (rx_data),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr),
    .busy      (busy)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      byte_idx      <= '0;
      mem.con_write <= '0;
      mem.con_addr  <= '0;
      mem.con_in    <= '0;
      done          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      mem.con_write <= 4'h0;
      if (rx_ferr) frame_err <= 1'b1;
      // address moves only after the pulse; last word pins it
      if (mem.con_write == 4'hF) begin
        if (mem.con_addr == LAST) done <= 1'b1;
        else mem.con_addr <= mem.con_addr + 10'd1;
      end
      if (rx_valid) begin
        mem.con_in[{byte_idx, 3'b000} +: 8] <= rx_data;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3 && !done) mem.con_write <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_uart_datamemload.sv
// Self-checking bench for uart_datamemload (CLKS_PER_BIT=16, NUM_WORDS=4).
// Table-driven word loads plus directed multi-cycle corner sequences.
module tb_uart_datamemload;

  localparam int C = 16;

  logic CLK = 1'b0;
  logic rst = 1'b0;
  logic RX  = 1'b1;
  logic busy;
  logic done;
  logic frame_err;

  uart_datamemload_if mem();

  uart_datamemload #(
    .CLKS_PER_BIT(C),
    .NUM_WORDS   (4)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .RX       (RX),
    .mem      (mem),
    .busy     (busy),
    .done     (done),
    .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  w;
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];

  always @(negedge CLK) begin
    if (mem.con_write != 4'h0) wq.push_back({mem.con_write, mem.con_addr, mem.con_in});
  end

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic        exp_wr;
    logic [31:0] exp_data;
    logic [9:0]  exp_addr;
    logic [9:0]  exp_addr_after;
    logic        exp_done;
  } vec_t;

  vec_t vec[5];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1;
    RX  = 1'b1;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int gap);
    RX = 1'b0;
    repeat (C) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (C) @(negedge CLK);
    end
    RX = stop;
    repeat (C) @(negedge CLK);
    RX = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic chk_wr(input string nm, input int idx,
                        input logic [9:0] a, input logic [31:0] d);
    if (idx >= wq.size()) begin
      chk({nm, "_present"}, 32'(wq.size()), 32'(idx + 1));
    end else begin
      chk({nm, "_strobe"}, 32'(wq[idx].w), 32'hF);
      chk({nm, "_addr"}, 32'(wq[idx].a), 32'(a));
      chk({nm, "_data"}, wq[idx].d, d);
    end
  endtask

  initial begin
    int n0;
    int t_rise;
    int t_fall;
    logic [7:0] pb;

    vec[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 1'b1, 32'h12345678,
               10'd0, 10'd1, 1'b0};
    vec[1] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b1, 32'hDEADBEEF,
               10'd1, 10'd2, 1'b0};
    vec[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 32'hFF00FF00,
               10'd2, 10'd3, 1'b0};
    vec[3] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 1'b1, 32'hFE7F8001,
               10'd3, 10'd3, 1'b1};
    vec[4] = '{8'h55, 8'h55, 8'h55, 8'h55, 1'b0, 32'h0,
               10'd3, 10'd3, 1'b1};

    // reset state
    do_reset();
    @(negedge CLK);
    chk("rst_write", 32'(mem.con_write), 32'h0);
    chk("rst_addr", 32'(mem.con_addr), 32'h0);
    chk("rst_in", mem.con_in, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);

    // single word
    send_byte(8'h78, 1'b1, 2);
    send_byte(8'h56, 1'b1, 2);
    send_byte(8'h34, 1'b1, 2);
    send_byte(8'h12, 1'b1, 4);
    chk("w1_count", 32'(wq.size()), 32'd1);
    chk_wr("w1", 0, 10'd0, 32'h12345678);
    chk("w1_addr_after", 32'(mem.con_addr), 32'd1);
    chk("w1_write_idle", 32'(mem.con_write), 32'h0);

    // start-bit glitch
    do_reset();
    t_rise = -1;
    t_fall = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (busy && t_rise < 0) t_rise = i;
      if (!busy && t_rise >= 0 && t_fall < 0) t_fall = i;
      if (i == 0) RX = 1'b0;
      if (i == 5) RX = 1'b1;
    end
    chk("gl_busy_rose", 32'(t_rise >= 0), 32'd1);
    chk("gl_busy_fell", 32'(t_fall >= 0), 32'd1);
    chk("gl_busy_len_le10", 32'((t_fall - t_rise) <= 10), 32'd1);
    chk("gl_no_write", 32'(wq.size()), 32'd0);
    chk("gl_addr", 32'(mem.con_addr), 32'd0);
    chk("gl_ferr", 32'(frame_err), 32'd0);

    // framing error then a clean word
    do_reset();
    send_byte(8'hAA, 1'b0, 4);
    chk("fe_flag", 32'(frame_err), 32'd1);
    send_byte(8'h01, 1'b1, 2);
    send_byte(8'h02, 1'b1, 2);
    send_byte(8'h03, 1'b1, 2);
    send_byte(8'h04, 1'b1, 4);
    chk("fe_count", 32'(wq.size()), 32'd1);
    chk_wr("fe", 0, 10'd0, 32'h04030201);
    chk("fe_sticky", 32'(frame_err), 32'd1);

    // table: fill all words then overflow
    do_reset();
    for (int v = 0; v < 5; v++) begin
      n0 = wq.size();
      send_byte(vec[v].b0, 1'b1, 2);
      send_byte(vec[v].b1, 1'b1, 2);
      send_byte(vec[v].b2, 1'b1, 2);
      send_byte(vec[v].b3, 1'b1, 4);
      chk($sformatf("tv%0d_count", v), 32'(wq.size() - n0),
          32'(vec[v].exp_wr));
      if (vec[v].exp_wr)
        chk_wr($sformatf("tv%0d", v), n0, vec[v].exp_addr,
               vec[v].exp_data);
      chk($sformatf("tv%0d_addr_after", v), 32'(mem.con_addr),
          32'(vec[v].exp_addr_after));
      chk($sformatf("tv%0d_done", v), 32'(done), 32'(vec[v].exp_done));
    end
    chk("tv_total_writes", 32'(wq.size()), 32'd4);

    // reset during bit 4 of the 2nd byte
    send_byte(8'h11, 1'b0, 4);
    chk("mr_ferr_pre", 32'(frame_err), 32'd1);
    pb = 8'hC3;
    RX = 1'b0;
    repeat (C) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX = pb[i];
      repeat (C) @(negedge CLK);
    end
    RX = pb[4];
    repeat (C / 2) @(negedge CLK);
    do_reset();
    repeat (3 * C) @(negedge CLK);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_ferr", 32'(frame_err), 32'd0);
    chk("mr_addr", 32'(mem.con_addr), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    send_byte(8'hA1, 1'b1, 2);
    send_byte(8'hB2, 1'b1, 2);
    send_byte(8'hC3, 1'b1, 2);
    send_byte(8'hD4, 1'b1, 4);
    chk("mr_count", 32'(wq.size()), 32'd1);
    chk_wr("mr", 0, 10'd0, 32'hD4C3B2A1);

    // back-to-back frames, no idle between stop and start
    do_reset();
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 0);
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h66, 1'b1, 0);
    send_byte(8'h77, 1'b1, 0);
    send_byte(8'h88, 1'b1, 4);
    chk("bb_count", 32'(wq.size()), 32'd2);
    chk_wr("bb0", 0, 10'd0, 32'h44332211);
    chk_wr("bb1", 1, 10'd1, 32'h88776655);
    chk("bb_addr_after", 32'(mem.con_addr), 32'd2);
    chk("bb_ferr", 32'(frame_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
